// File: rtl/mips_run_monitor.sv
// Run controller and self-check monitor for the single-cycle MIPS core: sequences core reset,
// watches the store bus and reports pass/fail. Optional PC-hang detection under `HANG_DETECT_EN`.
module mips_run_monitor #(
    parameter int                 WIDTH        = 32,
    parameter int                 RESET_CYCLES = 2,
    parameter int                 TIMEOUT      = 1024,
    parameter int                 CNT_W        = 16,
    parameter logic [WIDTH-1:0]   PASS_ADDR    = 32'd84,
    parameter logic [WIDTH-1:0]   PASS_DATA    = 32'd7,
    parameter int                 HANG_CYCLES  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] dataadr,
    input  logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] pc,
    output logic             cpu_reset,
    output logic             running,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] write_cnt
);

    typedef enum logic [2:0] {IDLE, HOLD, RUN, PASSED, FAILED} state_t;

    localparam int               HOLD_W       = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]  write_cnt_q, write_cnt_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic [1:0]        fail_code_q, fail_code_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              running_q, running_d;
    logic              done_q, done_d;
    logic              hang_hit;

`ifdef HANG_DETECT_EN
    localparam int              HANG_W    = (HANG_CYCLES > 1) ? $clog2(HANG_CYCLES) : 1;
    localparam logic [HANG_W-1:0] HANG_LAST = HANG_W'(HANG_CYCLES - 1);

    logic [HANG_W-1:0] hang_cnt_q, hang_cnt_d;
    logic [WIDTH-1:0]  pc_prev_q;

    // pc_prev tracks every cycle so the first RUN cycle already has a valid reference.
    always_comb begin
        hang_cnt_d = '0;
        hang_hit   = 1'b0;
        if (state_q == RUN && pc == pc_prev_q) begin
            if (hang_cnt_q == HANG_LAST) begin
                hang_hit = 1'b1;
            end else begin
                hang_cnt_d = hang_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hang_cnt_q <= '0;
            pc_prev_q  <= '0;
        end else begin
            hang_cnt_q <= hang_cnt_d;
            pc_prev_q  <= pc;
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
    assign hang_hit  = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        write_cnt_d = write_cnt_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        fail_code_d = fail_code_q;

        case (state_q)
            IDLE, PASSED, FAILED: begin
                if (start) begin
                    state_d     = HOLD;
                    hold_cnt_d  = '0;
                    cycle_cnt_d = '0;
                    write_cnt_d = '0;
                    pass_d      = 1'b0;
                    fail_d      = 1'b0;
                    fail_code_d = 2'd0;
                end
            end
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            RUN: begin
                cycle_cnt_d = cycle_cnt_q + 1'b1;
                if (memwrite && write_cnt_q != {CNT_W{1'b1}}) begin
                    write_cnt_d = write_cnt_q + 1'b1;
                end
                // Signature store outranks hang, which outranks timeout.
                if (memwrite && dataadr == PASS_ADDR) begin
                    if (writedata == PASS_DATA) begin
                        state_d = PASSED;
                        pass_d  = 1'b1;
                    end else begin
                        state_d     = FAILED;
                        fail_d      = 1'b1;
                        fail_code_d = 2'd1;
                    end
                end else if (hang_hit) begin
                    state_d     = FAILED;
                    fail_d      = 1'b1;
                    fail_code_d = 2'd3;
                end else if (cycle_cnt_q == TIMEOUT_LAST) begin
                    state_d     = FAILED;
                    fail_d      = 1'b1;
                    fail_code_d = 2'd2;
                end
            end
            default: state_d = IDLE;
        endcase

        cpu_reset_d = (state_d == IDLE) || (state_d == HOLD);
        running_d   = (state_d == RUN);
        done_d      = (state_d == PASSED) || (state_d == FAILED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            hold_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            write_cnt_q <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_code_q <= 2'd0;
            cpu_reset_q <= 1'b1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            write_cnt_q <= write_cnt_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            fail_code_q <= fail_code_d;
            cpu_reset_q <= cpu_reset_d;
            running_q   <= running_d;
            done_q      <= done_d;
        end
    end

    assign cpu_reset = cpu_reset_q;
    assign running   = running_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign fail_code = fail_code_q;
    assign cycle_cnt = cycle_cnt_q;
    assign write_cnt = write_cnt_q;

endmodule

// File: tb/tb_mips_run_monitor.sv
// Directed bench for mips_run_monitor (TIMEOUT=32); expected values are hand-derived per scenario.
module tb_mips_run_monitor;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             memwrite;
    logic [31:0]      dataadr;
    logic [31:0]      writedata;
    logic [31:0]      pc;
    logic             cpu_reset;
    logic             running;
    logic             done;
    logic             pass;
    logic             fail;
    logic [1:0]       fail_code;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] write_cnt;

    int  errors = 0;
    int  checks = 0;
    bit  pc_walk = 1'b1;

    mips_run_monitor #(
        .WIDTH(32), .RESET_CYCLES(2), .TIMEOUT(32), .CNT_W(CNT_W),
        .PASS_ADDR(32'd84), .PASS_DATA(32'd7), .HANG_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata), .pc(pc),
        .cpu_reset(cpu_reset), .running(running), .done(done), .pass(pass),
        .fail(fail), .fail_code(fail_code), .cycle_cnt(cycle_cnt), .write_cnt(write_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (pc_walk) pc = pc + 32'd4;
        end
    endtask

    task automatic store(input logic [31:0] adr, input logic [31:0] dat);
        memwrite  = 1'b1;
        dataadr   = adr;
        writedata = dat;
        step();
        memwrite  = 1'b0;
        dataadr   = '0;
        writedata = '0;
    endtask

    // start pulse, two HOLD edges, returns in the first RUN cycle
    task automatic launch();
        start = 1'b1;
        step();
        start = 1'b0;
        step(2);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; memwrite = 1'b0;
        dataadr = '0; writedata = '0; pc = '0;

        // 1: reset values, HOLD length
        step(2);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", {pass, fail, fail_code}, 0);
        chk("rst_counts", {cycle_cnt, write_cnt}, 0);
        reset = 1'b1;
        step();
        chk("idle_cpu_reset", cpu_reset, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("hold1_cpu_reset", cpu_reset, 1);
        chk("hold1_running", running, 0);
        step();
        chk("hold2_cpu_reset", cpu_reset, 1);
        chk("hold2_running", running, 0);
        step();
        chk("run_cpu_reset", cpu_reset, 0);
        chk("run_running", running, 1);
        chk("run_cycle0", cycle_cnt, 0);

        // 2: good signature on RUN cycle 10
        step(10);
        chk("run_cycle10", cycle_cnt, 10);
        store(32'd84, 32'd7);
        chk("pass_pass", pass, 1);
        chk("pass_done", done, 1);
        chk("pass_fail", fail, 0);
        chk("pass_code", fail_code, 0);
        chk("pass_cycle", cycle_cnt, 11);
        chk("pass_writes", write_cnt, 1);
        chk("pass_running", running, 0);
        chk("pass_cpu_reset", cpu_reset, 0);
        step(3);
        chk("pass_frozen", cycle_cnt, 11);
        chk("pass_sticky", pass, 1);

        // 5b: restart from PASS clears everything
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_cpu_reset", cpu_reset, 1);
        chk("restart_pass", pass, 0);
        chk("restart_done", done, 0);
        chk("restart_counts", {cycle_cnt, write_cnt}, 0);
        step(2);
        chk("restart_running", running, 1);

        // 3: other store then bad signature
        store(32'd80, 32'd3);
        chk("other_store_running", running, 1);
        store(32'd84, 32'd5);
        chk("bad_fail", fail, 1);
        chk("bad_pass", pass, 0);
        chk("bad_code", fail_code, 1);
        chk("bad_writes", write_cnt, 2);
        chk("bad_cycle", cycle_cnt, 2);

        // 4a: timeout
        launch();
        step(31);
        chk("to_before_running", running, 1);
        chk("to_before_cycle", cycle_cnt, 31);
        step();
        chk("to_fail", fail, 1);
        chk("to_code", fail_code, 2);
        chk("to_cycle", cycle_cnt, 32);
        chk("to_running", running, 0);

        // 4b: good signature on the timeout edge wins
        launch();
        step(31);
        store(32'd84, 32'd7);
        chk("to_sig_pass", pass, 1);
        chk("to_sig_fail", fail, 0);
        chk("to_sig_code", fail_code, 0);
        chk("to_sig_cycle", cycle_cnt, 32);

        // 5a: asynchronous reset mid-run
        launch();
        step(3);
        store(32'd40, 32'd1);
        chk("mid_writes", write_cnt, 1);
        #2 reset = 1'b0;
        #1;
        chk("abort_cpu_reset", cpu_reset, 1);
        chk("abort_running", running, 0);
        chk("abort_flags", {done, pass, fail, fail_code}, 0);
        chk("abort_counts", {cycle_cnt, write_cnt}, 0);
        step();
        reset = 1'b1;
        step(2);
        chk("abort_idle_cpu_reset", cpu_reset, 1);
        chk("abort_idle_running", running, 0);

        // 6: pc stuck at 0x3C
        pc_walk = 1'b0;
        pc = 32'h3C;
        launch();
        begin
            int budget = 64;
            while (!done && budget > 0) begin
                step();
                budget--;
            end
        end
        chk("stall_done", done, 1);
        chk("stall_fail", fail, 1);
`ifdef HANG_DETECT_EN
        chk("stall_code", fail_code, 3);
        chk("stall_cycle", cycle_cnt, 8);
`else
        chk("stall_code", fail_code, 2);
        chk("stall_cycle", cycle_cnt, 32);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
